// File: rtl/sig_packer.sv
// sig_packer: packs a valid/ready byte stream into 3-byte frames for sub1.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_last byte input;
//   sig_a frame strobe, sig_b seq no, sig_c packed bytes, sig_d reversed bytes,
//   err drop pulse, err_cnt saturating drop count.
// Option: define SIG_PACKER_PARITY_EN for 4-byte frames with a trailing
//   parity byte (b0^b1^b2) checked in a CHK state.
module sig_packer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                sig_a,
  output logic [1:0]          sig_b,
  output logic [0:2][7:0]     sig_c,
  output logic [7:0]          sig_d [3],
  output logic                err,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam int CW =
    (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam int TO_M1 = TO_EN ? TIMEOUT_CYC - 1 : 0;

`ifdef SIG_PACKER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC1  = 3'd1,
    S_ACC2  = 3'd2,
    S_CHK   = 3'd3,
    S_EMIT  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC1  = 3'd1,
    S_ACC2  = 3'd2,
    S_EMIT  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`endif

  state_t          r_state;
  logic            r_ready;
  logic [CW-1:0]   r_idle;
  logic [7:0]      r_b0;
  logic [7:0]      r_b1;

  state_t          w_nxt;
  logic            w_acc;
  logic            w_timed;
  logic            w_to;
  logic            w_drop;
  logic            w_emit;
  logic [0:2][7:0] w_frame;

`ifdef SIG_PACKER_PARITY_EN
  logic [7:0]      r_b2;
  logic            w_par_ok;

  assign w_frame  = {r_b0, r_b1, r_b2};
  assign w_par_ok = (in_data == (r_b0 ^ r_b1 ^ r_b2));
  assign w_timed  = (r_state == S_ACC1) ||
                    (r_state == S_ACC2) ||
                    (r_state == S_CHK);
`else
  // Last byte is taken straight from the bus on the emitting edge.
  assign w_frame  = {r_b0, r_b1, in_data};
  assign w_timed  = (r_state == S_ACC1) ||
                    (r_state == S_ACC2);
`endif

  assign in_ready = r_ready;
  assign w_acc    = in_valid && r_ready;

  // Fires on the edge where the idle count would reach TIMEOUT_CYC;
  // an accept on the same edge takes priority.
  assign w_to = TO_EN && w_timed && !w_acc &&
                (r_idle == CW'(TO_M1));

  always_comb begin
    w_nxt  = r_state;
    w_drop = 1'b0;
    w_emit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (in_last) w_drop = 1'b1;
          else         w_nxt  = S_ACC1;
        end
      end
      S_ACC1: begin
        if (w_acc) begin
          if (in_last) begin
            w_drop = 1'b1;
            w_nxt  = S_IDLE;
          end else begin
            w_nxt  = S_ACC2;
          end
        end else if (w_to) begin
          w_drop = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
`ifdef SIG_PACKER_PARITY_EN
      S_ACC2: begin
        if (w_acc) begin
          if (in_last) begin
            w_drop = 1'b1;
            w_nxt  = S_IDLE;
          end else begin
            w_nxt  = S_CHK;
          end
        end else if (w_to) begin
          w_drop = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
      S_CHK: begin
        if (w_acc) begin
          if (in_last && w_par_ok) begin
            w_emit = 1'b1;
            w_nxt  = S_EMIT;
          end else if (in_last) begin
            w_drop = 1'b1;
            w_nxt  = S_IDLE;
          end else begin
            w_drop = 1'b1;
            w_nxt  = S_DRAIN;
          end
        end else if (w_to) begin
          w_drop = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
`else
      S_ACC2: begin
        if (w_acc) begin
          if (in_last) begin
            w_emit = 1'b1;
            w_nxt  = S_EMIT;
          end else begin
            w_drop = 1'b1;
            w_nxt  = S_DRAIN;
          end
        end else if (w_to) begin
          w_drop = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
`endif
      S_EMIT: begin
        w_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // One error was already counted on entry.
        if (w_acc && in_last) w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_idle  <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
`ifdef SIG_PACKER_PARITY_EN
      r_b2    <= '0;
`endif
      sig_a   <= 1'b0;
      sig_b   <= '0;
      sig_c   <= '0;
      for (int i = 0; i < 3; i++) sig_d[i] <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_ready <= (w_nxt != S_EMIT);
      sig_a   <= 1'b0;
      err     <= 1'b0;

      if (w_timed && !w_acc && !w_to && TO_EN)
        r_idle <= r_idle + 1'b1;
      else
        r_idle <= '0;

      if (w_acc && r_state == S_IDLE) r_b0 <= in_data;
      if (w_acc && r_state == S_ACC1) r_b1 <= in_data;
`ifdef SIG_PACKER_PARITY_EN
      if (w_acc && r_state == S_ACC2) r_b2 <= in_data;
`endif

      if (w_emit) begin
        sig_a <= 1'b1;
        sig_b <= sig_b + 2'd1;
        sig_c <= w_frame;
        for (int i = 0; i < 3; i++)
          sig_d[i] <= w_frame[2-i];
      end

      if (w_drop) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
